// File: rtl/id_regfile_scoreboard_if.sv
// Decode-side bus for id_regfile_scoreboard: read ports, issue handshake, writeback, flush, pending count.
interface id_regfile_scoreboard_if #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 5,
  parameter int unsigned NREAD  = 2
);
  logic [NREAD*AWIDTH-1:0] rd_addr;
  logic [NREAD-1:0]        rd_used;
  logic [NREAD*DWIDTH-1:0] rd_data;
  logic [NREAD-1:0]        rd_busy;
  logic                    issue_valid;
  logic                    issue_we;
  logic [AWIDTH-1:0]       issue_rd;
  logic                    issue_ready;
  logic                    wb_we;
  logic [AWIDTH-1:0]       wb_addr;
  logic [DWIDTH-1:0]       wb_data;
  logic                    flush;
  logic [AWIDTH:0]         pending_cnt;

  modport master (
    output rd_addr, rd_used, issue_valid, issue_we, issue_rd,
    output wb_we, wb_addr, wb_data, flush,
    input  rd_data, rd_busy, issue_ready, pending_cnt
  );

  modport slave (
    input  rd_addr, rd_used, issue_valid, issue_we, issue_rd,
    input  wb_we, wb_addr, wb_data, flush,
    output rd_data, rd_busy, issue_ready, pending_cnt
  );
endinterface

// File: rtl/id_regfile_scoreboard.sv
// Decode-stage register file with per-register busy scoreboard producing the RAW/WAW issue stall.
// Optional macro RF_WB_BYPASS_EN: same-cycle writeback forwarding to reads and to the stall logic.
module id_regfile_scoreboard #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 5,
  parameter int unsigned NREAD  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  id_regfile_scoreboard_if.slave bus
);
  localparam int unsigned NREGS  = 2**AWIDTH;
  localparam int unsigned CWIDTH = AWIDTH + 1;

  logic [DWIDTH-1:0] regs_q [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [NREGS-1:0]  wb_hit;
  logic [NREGS-1:0]  eff_busy;
  logic [CWIDTH-1:0] pending_cnt_q, pending_cnt_d;
  logic              src_blocked;
  logic              waw_blocked;
  logic              fire;

  // One-hot of the register being written back this cycle (x0 never hit)
  always_comb begin
    wb_hit = '0;
    if (bus.wb_we && (bus.wb_addr != '0)) wb_hit[bus.wb_addr] = 1'b1;
  end

`ifdef RF_WB_BYPASS_EN
  assign eff_busy = busy_q & ~wb_hit;
`else
  assign eff_busy = busy_q;
`endif

  // Interlock: any used source or the destination still awaiting writeback blocks issue
  always_comb begin
    src_blocked = 1'b0;
    for (int unsigned i = 0; i < NREAD; i++) begin
      src_blocked = src_blocked |
                    (bus.rd_used[i] & eff_busy[bus.rd_addr[i*AWIDTH +: AWIDTH]]);
    end
    waw_blocked     = bus.issue_we & (bus.issue_rd != '0) & eff_busy[bus.issue_rd];
    bus.issue_ready = ~src_blocked & ~waw_blocked & ~bus.flush;
    fire            = bus.issue_valid & bus.issue_ready;
  end

  // Asynchronous read ports
  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int unsigned i = 0; i < NREAD; i++) begin
      bus.rd_data[i*DWIDTH +: DWIDTH] = regs_q[bus.rd_addr[i*AWIDTH +: AWIDTH]];
      bus.rd_busy[i]                  = busy_q[bus.rd_addr[i*AWIDTH +: AWIDTH]];
`ifdef RF_WB_BYPASS_EN
      if (wb_hit[bus.rd_addr[i*AWIDTH +: AWIDTH]]) begin
        bus.rd_data[i*DWIDTH +: DWIDTH] = bus.wb_data;
      end
`endif
    end
  end

  // Next busy vector: writeback clears, issue sets (set wins), flush clears all
  always_comb begin
    busy_d = busy_q;
    if (bus.flush) begin
      busy_d = '0;
    end else begin
      busy_d = busy_d & ~wb_hit;
      if (fire && bus.issue_we && (bus.issue_rd != '0)) busy_d[bus.issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
    pending_cnt_d = '0;
    for (int unsigned r = 0; r < NREGS; r++) begin
      pending_cnt_d = pending_cnt_d + CWIDTH'(busy_d[r]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q        <= '0;
      pending_cnt_q <= '0;
      for (int unsigned r = 0; r < NREGS; r++) regs_q[r] <= '0;
    end else begin
      busy_q        <= busy_d;
      pending_cnt_q <= pending_cnt_d;
      if (bus.wb_we && (bus.wb_addr != '0)) regs_q[bus.wb_addr] <= bus.wb_data;
    end
  end

  assign bus.pending_cnt = pending_cnt_q;
endmodule

// File: tb/tb_id_regfile_scoreboard.sv
// Directed self-checking bench for id_regfile_scoreboard (default parameters).
module tb_id_regfile_scoreboard;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  id_regfile_scoreboard_if #(.DWIDTH(32), .AWIDTH(5), .NREAD(2)) bus ();

  id_regfile_scoreboard #(.DWIDTH(32), .AWIDTH(5), .NREAD(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.rd_addr     = '0;
    bus.rd_used     = '0;
    bus.issue_valid = 1'b0;
    bus.issue_we    = 1'b0;
    bus.issue_rd    = '0;
    bus.wb_we       = 1'b0;
    bus.wb_addr     = '0;
    bus.wb_data     = '0;
    bus.flush       = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    bus.issue_valid = 1'b1;
    bus.issue_we    = 1'b1;
    bus.issue_rd    = rd;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.pending_cnt !== 6'd0) begin
      n_fail++; $display("FAIL reset_pending: got %0d want 0", bus.pending_cnt);
    end
    n_cmp++;
    if (bus.issue_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b want 1", bus.issue_ready);
    end
    for (int a = 0; a < 32; a++) begin
      bus.rd_addr = {5'(a), 5'(a)};
      #1;
      n_cmp++;
      if (bus.rd_data !== 64'd0 || bus.rd_busy !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_read x%0d: data %h busy %b want 0 / 00", a, bus.rd_data, bus.rd_busy);
      end
    end
    idle();
  endtask

  task automatic test_write_read();
    bus.wb_we = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'hDEADBEEF;
    tick();
    idle();
    bus.rd_addr = {5'd5, 5'd0};
    #1;
    n_cmp++;
    if (bus.rd_data[63:32] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL write_x5: got %h want deadbeef", bus.rd_data[63:32]);
    end
    bus.wb_we = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'h1234;
    tick();
    idle();
    #1;
    n_cmp++;
    if (bus.rd_data[31:0] !== 32'd0) begin
      n_fail++; $display("FAIL write_x0: got %h want 0", bus.rd_data[31:0]);
    end
  endtask

  task automatic test_raw();
    issue(5'd7);
    bus.rd_used = 2'b01; bus.rd_addr = {5'd0, 5'd7};
    bus.issue_valid = 1'b1; bus.issue_we = 1'b0;
    #1;
    n_cmp++;
    if (bus.issue_ready !== 1'b0 || bus.pending_cnt !== 6'd1 || bus.rd_busy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL raw_stall: ready %b cnt %0d busy %b want 0 1 1",
               bus.issue_ready, bus.pending_cnt, bus.rd_busy[0]);
    end
    bus.wb_we = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'h55;
    #1;
`ifdef RF_WB_BYPASS_EN
    n_cmp++;
    if (bus.issue_ready !== 1'b1 || bus.rd_data[31:0] !== 32'h55) begin
      n_fail++;
      $display("FAIL raw_wb_cycle: ready %b data %h want 1 55", bus.issue_ready, bus.rd_data[31:0]);
    end
`else
    n_cmp++;
    if (bus.issue_ready !== 1'b0 || bus.rd_data[31:0] !== 32'd0) begin
      n_fail++;
      $display("FAIL raw_wb_cycle: ready %b data %h want 0 0", bus.issue_ready, bus.rd_data[31:0]);
    end
`endif
    tick();
    bus.wb_we = 1'b0;
    #1;
    n_cmp++;
    if (bus.issue_ready !== 1'b1 || bus.rd_data[31:0] !== 32'h55 || bus.pending_cnt !== 6'd0) begin
      n_fail++;
      $display("FAIL raw_after_wb: ready %b data %h cnt %0d want 1 55 0",
               bus.issue_ready, bus.rd_data[31:0], bus.pending_cnt);
    end
    idle();
  endtask

  task automatic test_waw();
    issue(5'd3);
    bus.issue_valid = 1'b1; bus.issue_we = 1'b1; bus.issue_rd = 5'd3;
    #1;
    n_cmp++;
    if (bus.issue_ready !== 1'b0) begin
      n_fail++; $display("FAIL waw_stall: ready %b want 0", bus.issue_ready);
    end
    idle();
    bus.wb_we = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'h33;
    tick();
    idle();
    n_cmp++;
    if (bus.pending_cnt !== 6'd0) begin
      n_fail++; $display("FAIL waw_clear: cnt %0d want 0", bus.pending_cnt);
    end
    // same-cycle writeback and new reservation on x9
    bus.wb_we = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 32'h99;
    bus.issue_valid = 1'b1; bus.issue_we = 1'b1; bus.issue_rd = 5'd9;
    #1;
    n_cmp++;
    if (bus.issue_ready !== 1'b1) begin
      n_fail++; $display("FAIL race_ready: ready %b want 1", bus.issue_ready);
    end
    tick();
    idle();
    bus.rd_addr = {5'd0, 5'd9};
    #1;
    n_cmp++;
    if (bus.rd_busy[0] !== 1'b1 || bus.pending_cnt !== 6'd1 || bus.rd_data[31:0] !== 32'h99) begin
      n_fail++;
      $display("FAIL race_set_wins: busy %b cnt %0d data %h want 1 1 99",
               bus.rd_busy[0], bus.pending_cnt, bus.rd_data[31:0]);
    end
    idle();
    bus.wb_we = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 32'h99;
    tick();
    idle();
  endtask

  task automatic test_flush();
    issue(5'd10);
    issue(5'd11);
    issue(5'd12);
    n_cmp++;
    if (bus.pending_cnt !== 6'd3) begin
      n_fail++; $display("FAIL flush_pre: cnt %0d want 3", bus.pending_cnt);
    end
    bus.flush = 1'b1;
    bus.issue_valid = 1'b1; bus.issue_we = 1'b1; bus.issue_rd = 5'd13;
    bus.wb_we = 1'b1; bus.wb_addr = 5'd2; bus.wb_data = 32'hA5;
    #1;
    n_cmp++;
    if (bus.issue_ready !== 1'b0) begin
      n_fail++; $display("FAIL flush_ready: ready %b want 0", bus.issue_ready);
    end
    tick();
    idle();
    n_cmp++;
    if (bus.pending_cnt !== 6'd0) begin
      n_fail++; $display("FAIL flush_cnt: cnt %0d want 0", bus.pending_cnt);
    end
    for (int a = 10; a < 14; a++) begin
      bus.rd_addr = {5'(a), 5'(a)};
      #1;
      n_cmp++;
      if (bus.rd_busy !== 2'b00) begin
        n_fail++; $display("FAIL flush_busy x%0d: busy %b want 00", a, bus.rd_busy);
      end
    end
    bus.rd_addr = {5'd0, 5'd2};
    #1;
    n_cmp++;
    if (bus.rd_data[31:0] !== 32'hA5) begin
      n_fail++; $display("FAIL flush_wb_x2: got %h want a5", bus.rd_data[31:0]);
    end
    // late writeback to a flushed register
    bus.wb_we = 1'b1; bus.wb_addr = 5'd10; bus.wb_data = 32'h77;
    tick();
    idle();
    bus.rd_addr = {5'd0, 5'd10};
    #1;
    n_cmp++;
    if (bus.rd_data[31:0] !== 32'h77 || bus.rd_busy[0] !== 1'b0 || bus.pending_cnt !== 6'd0) begin
      n_fail++;
      $display("FAIL late_wb: data %h busy %b cnt %0d want 77 0 0",
               bus.rd_data[31:0], bus.rd_busy[0], bus.pending_cnt);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    issue(5'd20);
    issue(5'd21);
    issue(5'd22);
    issue(5'd23);
    n_cmp++;
    if (bus.pending_cnt !== 6'd4) begin
      n_fail++; $display("FAIL rstmid_pre: cnt %0d want 4", bus.pending_cnt);
    end
    rst = 1'b1;
    bus.wb_we = 1'b1; bus.wb_addr = 5'd20; bus.wb_data = 32'hFF;
    tick();
    rst = 1'b0;
    idle();
    n_cmp++;
    if (bus.pending_cnt !== 6'd0) begin
      n_fail++; $display("FAIL rstmid_cnt: cnt %0d want 0", bus.pending_cnt);
    end
    for (int a = 0; a < 32; a++) begin
      bus.rd_addr = {5'(a), 5'(a)};
      #1;
      n_cmp++;
      if (bus.rd_data !== 64'd0 || bus.rd_busy !== 2'b00) begin
        n_fail++;
        $display("FAIL rstmid_read x%0d: data %h busy %b want 0 / 00", a, bus.rd_data, bus.rd_busy);
      end
    end
    idle();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    idle();
    test_reset();
    test_write_read();
    test_raw();
    test_waw();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
